if_id_skid_reg: RTL and testbench
=================================

Name: if_id_skid_reg

Overview:
- Parametrised successor of the IF/ID pipeline register. Sits between fetch and decode.
- Carries LANES instruction/PC-plus-4 pairs, with a per-lane valid mask.
- Replaces the bare hold input with a valid/ready handshake and a 2-entry skid buffer, so fetch-side ready is a registered signal.
- Flush is defined on every cycle, independent of stall state, and inserts a bubble (NOP).

Parameters:
- LANES, 1, number of instructions fetched per cycle.
- INSTR_W, 32, instruction width.
- PC_W, 32, PC-plus-4 width.
- NOP_INSTR, 32'h0000_0000, value driven on instruction lanes when a lane is empty or flushed.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  fetch presents a bundle.
- in_ready  out  1  register can accept a bundle this cycle.
- in_lane_mask  in  LANES  per-lane valid bits of the incoming bundle.
- in_instr  in  LANES*INSTR_W  instructions; lane 0 in the LSBs.
- in_pcplus4  in  LANES*PC_W  PC+4 per lane.
- flush  in  1  discard all held and incoming bundles (branch/jump redirect).
- out_valid  out  1  decode bundle valid.
- out_ready  in  1  decode consumes the bundle this cycle (low = stall).
- out_lane_mask  out  LANES  per-lane valid.
- out_instr  out  LANES*INSTR_W  instructions to decode.
- out_pcplus4  out  LANES*PC_W  PC+4 to decode.

Behaviour:
- Storage: a main register drives the outputs; a skid register holds one spill bundle.
- State is {main_v, skid_v}. The legal states are EMPTY (0,0), ONE (1,0) and FULL (1,1).
- Handshake definitions:
  - Accept = in_valid & in_ready.
  - Consume = out_valid & out_ready.
  - in_ready is a registered value equal to !skid_v.
  - No combinational path from out_ready to in_ready.
- Transitions when flush = 0:
  - EMPTY + accept -> ONE; main <= input.
  - ONE + consume, no accept -> EMPTY.
  - ONE + accept + consume -> ONE; main <= input.
  - ONE + accept, no consume -> FULL; skid <= input; in_ready drops the next cycle.
  - FULL + consume -> ONE; main <= skid. No accept is possible in FULL.
  - Otherwise hold all state.
- Latency: 1 cycle from accept to out_valid when the register is EMPTY. Throughput: 1 bundle per cycle when out_ready is held high.
- Flush (priority: rst > flush > handshake):
  - Next state is EMPTY, in_ready <= 1.
  - out_lane_mask <= 0 and out_instr <= NOP_INSTR on all lanes; out_pcplus4 is retained.
  - The bundle presented in the flush cycle is dropped even if in_valid & in_ready.
  - A consume in the flush cycle still counts as a transfer to decode.
- Reset:
  - State EMPTY, in_ready = 1, out_valid = 0, out_lane_mask = 0.
  - out_instr = NOP_INSTR on all lanes, out_pcplus4 = 0, skid contents = 0.
  - Reset mid-stall discards both entries.
- Empty lanes: when out_valid = 0, or a lane's mask bit = 0, that lane's out_instr reads NOP_INSTR. Decode never sees stale instructions.
- Handshake stability: out_* is stable while out_valid & !out_ready. The bench asserts this.
- An accepted bundle with in_lane_mask = 0 is still stored as a valid bundle. No filtering is done here.

Optional Feature:
- Macro: IF_ID_PERF_CNT_EN.
- Enabled: adds three 32-bit outputs.
  - perf_stall_cyc: counts cycles with out_valid & !out_ready.
  - perf_flush_cnt: counts flush pulses where main_v | skid_v.
  - perf_skid_cnt: counts entries into FULL.
- Counter rules: counters saturate at 32'hFFFF_FFFF and reset to 0.
- Disabled: ports and logic are absent; the functional behaviour above is identical.

Decomposition:
- Package pipe_pkg holds:
  - the NOP_INSTR default;
  - localparams for the state encoding {EMPTY, ONE, FULL};
  - a function pack_lanes/lane_slice for LANES-wide bus indexing.
- One sub-module: skid_buf_2 (generic DATA_W 2-entry skid buffer with flush). if_id_skid_reg packs mask/instr/pc into its data word and applies NOP masking on the output.

Test Plan:
- Reset check: assert rst for 2 cycles -> out_valid = 0, in_ready = 1, out_instr = 32'h0, out_pcplus4 = 0.
- Streaming, LANES = 2: out_ready = 1; send instr {32'h2002_0005, 32'h2003_0007} with pcplus4 {4, 8} for 4 bundles -> each appears 1 cycle later; one bundle per cycle; in_ready never drops.
- Stall/skid: out_ready = 0 after bundle A is in main; accept B -> FULL, in_ready = 0 the next cycle. B must be held, not lost. Raise out_ready -> A then B on consecutive cycles; in_ready = 1 after A is consumed.
- Flush in FULL: flush = 1 with in_valid = 1 carrying C -> next cycle out_valid = 0, out_instr = NOP_INSTR; C never appears at the output; in_ready = 1.
- Lane mask: accept a bundle with mask 2'b01 -> lane 1 out_instr = NOP_INSTR; lane 0 carries the data.
- Perf (IF_ID_PERF_CNT_EN): 5 stall cycles, 2 flushes while occupied -> perf_stall_cyc = 5, perf_flush_cnt = 2.

Source files
------------

// File: rtl/pipe_pkg.sv
//------------------------------------------------------------------------------
// Module  : pipe_pkg
// Purpose : Shared NOP default, skid-buffer state encoding and lane helpers.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package pipe_pkg;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

  // State bits are {main_v, skid_v}; (0,1) is unreachable.
  localparam logic [1:0] ST_EMPTY_ENC = 2'b00;
  localparam logic [1:0] ST_ONE_ENC   = 2'b10;
  localparam logic [1:0] ST_FULL_ENC  = 2'b11;

  typedef enum logic [1:0] {
    ST_EMPTY = ST_EMPTY_ENC,
    ST_ONE   = ST_ONE_ENC,
    ST_FULL  = ST_FULL_ENC
  } buf_state_e;

  function automatic int unsigned lane_slice(input int unsigned lane,
                                             input int unsigned width);
    return lane * width;
  endfunction

endpackage

`default_nettype wire

// File: rtl/skid_buf_2.sv
//------------------------------------------------------------------------------
// Module  : skid_buf_2
// Purpose : Generic 2-entry skid buffer with registered in_ready and flush.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module skid_buf_2
  import pipe_pkg::*;
#(
  parameter int              DATA_W   = 8,
  parameter logic [DATA_W-1:0] RST_DATA = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [DATA_W-1:0] flush_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  buf_state_e        state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_ready_q;
  logic              accept, consume;

  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;
  assign in_ready  = in_ready_q;
  assign accept    = in_valid & in_ready_q;
  assign consume   = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = flush_data;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d = ST_ONE;
            main_d  = in_data;
          end
        end
        ST_ONE: begin
          if (accept && consume) begin
            main_d = in_data;
          end else if (accept) begin
            state_d = ST_FULL;
            skid_d  = in_data;
          end else if (consume) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (consume) begin
            state_d = ST_ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      main_q     <= RST_DATA;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      // Registered so out_ready never reaches in_ready combinationally.
      in_ready_q <= (state_d != ST_FULL);
    end
  end

endmodule

`default_nettype wire

// File: rtl/if_id_skid_reg.sv
//------------------------------------------------------------------------------
// Module  : if_id_skid_reg
// Purpose : IF/ID register with valid/ready skid buffer, flush and NOP masking.
//           Optional perf counters under IF_ID_PERF_CNT_EN.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module if_id_skid_reg
  import pipe_pkg::*;
#(
  parameter int                 LANES     = 1,
  parameter int                 INSTR_W   = 32,
  parameter int                 PC_W      = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEFAULT)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES-1:0]         in_lane_mask,
  input  logic [LANES*INSTR_W-1:0] in_instr,
  input  logic [LANES*PC_W-1:0]    in_pcplus4,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES-1:0]         out_lane_mask,
  output logic [LANES*INSTR_W-1:0] out_instr,
  output logic [LANES*PC_W-1:0]    out_pcplus4
`ifdef IF_ID_PERF_CNT_EN
  ,
  output logic [31:0]              perf_stall_cyc,
  output logic [31:0]              perf_flush_cnt,
  output logic [31:0]              perf_skid_cnt
`endif
);

  // Data word layout: {pcplus4, instr, mask}.
  localparam int DATA_W   = LANES * (1 + INSTR_W + PC_W);
  localparam int INSTR_LO = LANES;
  localparam int PC_LO    = LANES * (1 + INSTR_W);
  localparam logic [DATA_W-1:0] RST_DATA =
    {{(LANES*PC_W){1'b0}}, {LANES{NOP_INSTR}}, {LANES{1'b0}}};

  logic [DATA_W-1:0] w_in_data, w_flush_data, w_buf_data;
  logic              w_buf_valid;

  assign w_in_data    = {in_pcplus4, in_instr, in_lane_mask};
  assign w_flush_data = {w_buf_data[DATA_W-1:PC_LO], {LANES{NOP_INSTR}}, {LANES{1'b0}}};

  skid_buf_2 #(
    .DATA_W   (DATA_W),
    .RST_DATA (RST_DATA)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .flush_data (w_flush_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (w_in_data),
    .out_valid  (w_buf_valid),
    .out_ready  (out_ready),
    .out_data   (w_buf_data)
  );

  assign out_valid     = w_buf_valid;
  assign out_lane_mask = w_buf_data[LANES-1:0] & {LANES{w_buf_valid}};
  assign out_pcplus4   = w_buf_data[DATA_W-1:PC_LO];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign out_instr[lane_slice(l, INSTR_W) +: INSTR_W] =
      out_lane_mask[l] ? w_buf_data[INSTR_LO + lane_slice(l, INSTR_W) +: INSTR_W]
                       : NOP_INSTR;
  end

`ifdef IF_ID_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_flush_q, perf_skid_q;
  logic        w_stall, w_flush_occ, w_skid_enter;

  assign w_stall      = w_buf_valid & ~out_ready;
  assign w_flush_occ  = flush & w_buf_valid;
  // ONE + accept without consume is the only way into FULL.
  assign w_skid_enter = ~flush & in_valid & in_ready & w_buf_valid & ~out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
      perf_skid_q  <= '0;
    end else begin
      if (w_stall && perf_stall_q != 32'hFFFF_FFFF) perf_stall_q <= perf_stall_q + 32'd1;
      if (w_flush_occ && perf_flush_q != 32'hFFFF_FFFF) perf_flush_q <= perf_flush_q + 32'd1;
      if (w_skid_enter && perf_skid_q != 32'hFFFF_FFFF) perf_skid_q <= perf_skid_q + 32'd1;
    end
  end

  assign perf_stall_cyc = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
  assign perf_skid_cnt  = perf_skid_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_id_skid_reg.sv
//------------------------------------------------------------------------------
// Module  : tb_if_id_skid_reg
// Purpose : Scoreboard bench for if_id_skid_reg (LANES=2), directed + random.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_if_id_skid_reg;

  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef struct packed {
    logic [1:0]  mask;
    logic [63:0] instr;
    logic [63:0] pc;
  } bundle_t;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic [1:0]  in_lane_mask, out_lane_mask;
  logic [63:0] in_instr, in_pcplus4, out_instr, out_pcplus4;
`ifdef IF_ID_PERF_CNT_EN
  logic [31:0] perf_stall_cyc, perf_flush_cnt, perf_skid_cnt;
`endif

  always #5 clk = ~clk;

  if_id_skid_reg #(.LANES(2), .INSTR_W(32), .PC_W(32), .NOP_INSTR(NOP)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_lane_mask  (in_lane_mask),
    .in_instr      (in_instr),
    .in_pcplus4    (in_pcplus4),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_lane_mask (out_lane_mask),
    .out_instr     (out_instr),
    .out_pcplus4   (out_pcplus4)
`ifdef IF_ID_PERF_CNT_EN
    ,
    .perf_stall_cyc(perf_stall_cyc),
    .perf_flush_cnt(perf_flush_cnt),
    .perf_skid_cnt (perf_skid_cnt)
`endif
  );

  // Reference: the register is a FIFO of at most two bundles.
  bundle_t     exp_q[$];
  logic [63:0] exp_pc = '0;
  bit          started = 0;
  bit          m_in_ready = 1, m_occ = 0;
  int          n_vec = 0, n_err = 0;
  int unsigned mdl_stall = 0, mdl_flush = 0, mdl_skid = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    bundle_t nb;
    if (rst) begin
      mdl_stall = 0; mdl_flush = 0; mdl_skid = 0;
    end else begin
      if (m_occ && !out_ready) mdl_stall++;
      if (flush && m_occ) mdl_flush++;
      if (!flush && in_valid && m_in_ready && m_occ && !out_ready) mdl_skid++;
    end
    if (rst) begin
      exp_q.delete();
      exp_pc = '0;
    end else if (flush) begin
      exp_q.delete();
    end else if (in_valid && m_in_ready) begin
      nb.mask = in_lane_mask; nb.instr = in_instr; nb.pc = in_pcplus4;
      exp_q.push_back(nb);
    end
    if (exp_q.size() > 0) exp_pc = exp_q[0].pc;
    started = 1;
  end

  bundle_t     b;
  logic [63:0] e_instr, p_instr, p_pc;
  logic [1:0]  e_mask, p_mask;
  bit          ev, prev_hold = 0;

  always @(negedge clk) begin
    if (started) begin
      ev = (exp_q.size() > 0);
      chk("in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
      chk("out_valid", 64'(out_valid), 64'(ev));
      if (ev) b = exp_q[0];
      else begin b.mask = 2'b00; b.instr = '0; b.pc = exp_pc; end
      e_mask = ev ? b.mask : 2'b00;
      for (int l = 0; l < 2; l++)
        e_instr[l*32 +: 32] = e_mask[l] ? b.instr[l*32 +: 32] : NOP;
      chk("out_lane_mask", 64'(out_lane_mask), 64'(e_mask));
      chk("out_instr", out_instr, e_instr);
      chk("out_pcplus4", out_pcplus4, b.pc);
      if (prev_hold) begin
        chk("stable_instr", out_instr, p_instr);
        chk("stable_pc", out_pcplus4, p_pc);
        chk("stable_mask", 64'(out_lane_mask), 64'(p_mask));
      end
      prev_hold = out_valid && !out_ready && !flush && !rst;
      p_instr = out_instr; p_pc = out_pcplus4; p_mask = out_lane_mask;
      m_in_ready = (exp_q.size() < 2);
      m_occ = ev;
      if (ev && out_ready) void'(exp_q.pop_front());
    end
  end

  task automatic drive(input bit v, input logic [1:0] m, input logic [31:0] i0, i1,
                       input logic [31:0] p0, p1, input bit ordy, input bit fl);
    in_valid = v; in_lane_mask = m; in_instr = {i1, i0}; in_pcplus4 = {p1, p0};
    out_ready = ordy; flush = fl;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 0; in_lane_mask = 0; in_instr = 0; in_pcplus4 = 0; out_ready = 0; flush = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    // Streaming
    for (int k = 0; k < 4; k++)
      drive(1, 2'b11, 32'h2002_0005, 32'h2003_0007, 4 + 8*k, 8 + 8*k, 1, 0);
    drive(0, 2'b00, 0, 0, 0, 0, 1, 0);
    // Stall / skid: A, B into FULL; D refused; drain
    drive(1, 2'b11, 32'hAAAA_0001, 32'hAAAA_0002, 32'h100, 32'h104, 0, 0);
    drive(1, 2'b11, 32'hBBBB_0001, 32'hBBBB_0002, 32'h200, 32'h204, 0, 0);
    drive(1, 2'b11, 32'hDDDD_0001, 32'hDDDD_0002, 32'h300, 32'h304, 0, 0);
    drive(0, 2'b00, 0, 0, 0, 0, 1, 0);
    drive(0, 2'b00, 0, 0, 0, 0, 1, 0);
    drive(0, 2'b00, 0, 0, 0, 0, 1, 0);
    // Flush in FULL with C presented
    drive(1, 2'b11, 32'h1111_0001, 32'h1111_0002, 32'h400, 32'h404, 0, 0);
    drive(1, 2'b11, 32'h2222_0001, 32'h2222_0002, 32'h500, 32'h504, 0, 0);
    drive(1, 2'b11, 32'hCCCC_0001, 32'hCCCC_0002, 32'h600, 32'h604, 0, 1);
    drive(0, 2'b00, 0, 0, 0, 0, 1, 0);
    // Lane mask 01, then empty mask stored as valid
    drive(1, 2'b01, 32'h5555_0001, 32'h5555_0002, 32'h700, 32'h704, 1, 0);
    drive(1, 2'b00, 32'h6666_0001, 32'h6666_0002, 32'h800, 32'h804, 1, 0);
    drive(0, 2'b00, 0, 0, 0, 0, 1, 0);
    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      drive(($urandom_range(0, 3) != 0), 2'($urandom), $urandom, $urandom, $urandom, $urandom,
            ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0));
    end
    rst = 1'b0;
    drive(0, 2'b00, 0, 0, 0, 0, 1, 0);
    drive(0, 2'b00, 0, 0, 0, 0, 1, 0);
`ifdef IF_ID_PERF_CNT_EN
    chk("perf_stall_cyc", 64'(perf_stall_cyc), 64'(mdl_stall));
    chk("perf_flush_cnt", 64'(perf_flush_cnt), 64'(mdl_flush));
    chk("perf_skid_cnt", 64'(perf_skid_cnt), 64'(mdl_skid));
`endif
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
